// File: rtl/i2s_msb_frame_receiver.sv
// i2s_msb_frame_receiver
//
// Captures a continuous MSB-first, left-justified I2S bit stream, one bit per
// clock. Each bit is written into a 1-bit-wide channel buffer RAM. The RAM is
// organised as a circular buffer of 256-bit frames (8 channels x 32 bits).
// The block publishes the slot index of the last completely written frame, so
// the downstream reader knows which slot is safe to read.
//
// Ports:
//   clk_i                  system clock; one serial bit per cycle
//   rst_ni                 synchronous active-low reset
//   i2s_running_i          stream valid; high = one valid data bit this cycle
//   i2s_data_i             serial data, MSB first
//   i2s_bclk_i             I2S bit clock (informational only, not sampled)
//   ram_write_addr_o       RAM write address {frame_idx, bit_idx}
//   ram_write_en_o         RAM write strobe
//   ram_write_data_o       bit to write
//   last_good_frame_idx_o  slot index of the last fully written frame
//
// All outputs are registered. The RAM commits a write on the edge after it is
// presented here.

module i2s_msb_frame_receiver #(
    parameter int CIRC_BUF_BITS = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       i2s_running_i,
    input  logic                       i2s_data_i,
    input  logic                       i2s_bclk_i,
    output logic [8+CIRC_BUF_BITS-1:0] ram_write_addr_o,
    output logic                       ram_write_en_o,
    output logic                       ram_write_data_o,
    output logic [CIRC_BUF_BITS-1:0]   last_good_frame_idx_o
);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_CAPTURE = 1'b1;

    localparam logic [CIRC_BUF_BITS-1:0] FRAME_ONE = CIRC_BUF_BITS'(1);

    logic [0:0]               state;
    logic [7:0]               bit_idx;
    logic [7:0]               bit_cur;
    logic [CIRC_BUF_BITS-1:0] frame_idx;
    logic [CIRC_BUF_BITS-1:0] last_good;

    // The bit clock is carried for interface compatibility; sampling is done
    // purely on clk_i.
    logic unused_bclk;
    assign unused_bclk = i2s_bclk_i;

    // The first running cycle after IDLE is always bit 0 of a frame, regardless
    // of where the free-running idle counter happens to be.
    always_comb begin
        bit_cur = 8'd0;
        if (state == ST_CAPTURE) begin
            bit_cur = bit_idx;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state            <= ST_IDLE;
            bit_idx          <= 8'd0;
            frame_idx        <= '0;
            last_good        <= '1;
            ram_write_en_o   <= 1'b0;
            ram_write_data_o <= 1'b0;
            ram_write_addr_o <= '0;
        end else if (i2s_running_i) begin
            state            <= ST_CAPTURE;
            ram_write_en_o   <= 1'b1;
            ram_write_data_o <= i2s_data_i;
            ram_write_addr_o <= {frame_idx, bit_cur};
            bit_idx          <= bit_cur + 8'd1;
            // Bit 255 closes the frame: publish it and advance to the next
            // slot, wrapping over the oldest frame.
            if (bit_cur == 8'hFF) begin
                last_good <= frame_idx;
                frame_idx <= frame_idx + FRAME_ONE;
            end
        end else begin
            state            <= ST_IDLE;
            ram_write_en_o   <= 1'b0;
            ram_write_addr_o <= {frame_idx, bit_idx};
            bit_idx          <= bit_idx + 8'd1;
            // An abandoned partial frame is retried in the same slot, because
            // last_good has not moved.
            frame_idx        <= last_good + FRAME_ONE;
        end
    end

    assign last_good_frame_idx_o = last_good;

endmodule

// File: tb/tb_i2s_msb_frame_receiver.sv
module tb_i2s_msb_frame_receiver;

    localparam int N     = 3;
    localparam int AW    = 8 + N;
    localparam int SLOTS = 1 << N;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          run = 1'b0;
    logic          din = 1'b0;
    logic [AW-1:0] wr_addr;
    logic          wr_en;
    logic          wr_data;
    logic [N-1:0]  last_good;

    i2s_msb_frame_receiver #(.CIRC_BUF_BITS(N)) dut (
        .clk_i                 (clk),
        .rst_ni                (rst_n),
        .i2s_running_i         (run),
        .i2s_data_i            (din),
        .i2s_bclk_i            (clk),
        .ram_write_addr_o      (wr_addr),
        .ram_write_en_o        (wr_en),
        .ram_write_data_o      (wr_data),
        .last_good_frame_idx_o (last_good)
    );

    always #5 clk = ~clk;

    // Channel buffer as seen by the reader: commits each presented write.
    logic tb_ram [DEPTH];
    always @(posedge clk) begin
        if (wr_en) tb_ram[wr_addr] <= wr_data;
    end

    // Reference model: frames are filled bit by bit into slot (last_good+1);
    // a frame becomes "good" once 256 bits have been collected; any gap in
    // running throws away the partial frame.
    logic mdl_mem     [DEPTH];
    bit   mdl_written [DEPTH];
    int   mdl_last_good;
    int   mdl_len;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic d);
        int exp_addr;
        exp_addr = 0;
        run = r;
        din = d;
        if (r) begin
            exp_addr = ((mdl_last_good + 1) % SLOTS) * 256 + mdl_len;
            mdl_mem[exp_addr]     = d;
            mdl_written[exp_addr] = 1'b1;
            mdl_len++;
            if (mdl_len == 256) begin
                mdl_last_good = (mdl_last_good + 1) % SLOTS;
                mdl_len       = 0;
            end
        end else begin
            mdl_len = 0;
        end
        @(posedge clk);
        #1;
        chk("en", 32'(wr_en), 32'(r));
        if (r) begin
            chk("addr", 32'(wr_addr), 32'(exp_addr));
            chk("data", 32'(wr_data), 32'(d));
        end
        chk("last_good", 32'(last_good), 32'(mdl_last_good));
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        run   = 1'b0;
        din   = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            chk("rst_en", 32'(wr_en), 32'd0);
            chk("rst_data", 32'(wr_data), 32'd0);
            chk("rst_last_good", 32'(last_good), 32'(SLOTS - 1));
        end
        rst_n         = 1'b1;
        mdl_last_good = SLOTS - 1;
        mdl_len       = 0;
    endtask

    task automatic idle(input int cycles, input logic d);
        for (int i = 0; i < cycles; i++) step(1'b0, d);
    endtask

    task automatic burst(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b1, 1'($urandom_range(0, 1)));
    endtask

    task automatic check_ram(input string tag);
        for (int a = 0; a < DEPTH; a++) begin
            if (mdl_written[a]) chk(tag, 32'(tb_ram[a]), 32'(mdl_mem[a]));
        end
    endtask

    initial begin
        for (int a = 0; a < DEPTH; a++) begin
            mdl_written[a] = 1'b0;
            mdl_mem[a]     = 1'b0;
        end
        mdl_last_good = SLOTS - 1;
        mdl_len       = 0;

        // Reset, then long idle with data held high.
        do_reset(4);
        idle(300, 1'b1);

        // Aligned burst of 8 frames: last_good steps 0..7.
        burst(2048);
        chk("burst_last_good", 32'(last_good), 32'd7);

        // Post-burst idle with data low: nothing written, RAM intact.
        idle(2048, 1'b0);
        chk("idle_last_good", 32'(last_good), 32'd7);
        check_ram("ram_burst");

        // Abort at bit 100 of frame 2, restart in the same slot.
        do_reset(2);
        idle(10, 1'b1);
        burst(2 * 256 + 100);
        step(1'b0, 1'b0);
        chk("abort_last_good", 32'(last_good), 32'd1);
        idle(5, 1'b0);
        step(1'b1, 1'($urandom_range(0, 1)));
        chk("abort_restart_addr", 32'(wr_addr), 32'h200);
        burst(255);
        chk("abort_done_last_good", 32'(last_good), 32'd2);

        // Running drops exactly on bit 255: frame not marked good, and a
        // rise one cycle later restarts the same slot at bit 0.
        burst(255);
        step(1'b0, 1'b1);
        chk("drop255_last_good", 32'(last_good), 32'd2);
        step(1'b1, 1'($urandom_range(0, 1)));
        chk("drop255_restart_addr", 32'(wr_addr), 32'h300);
        idle(3, 1'b0);
        check_ram("ram_abort");

        // Nine frames: frame 8 overwrites slot 0.
        do_reset(2);
        idle(7, 1'b0);
        burst(9 * 256);
        chk("wrap_last_good", 32'(last_good), 32'd0);
        idle(2, 1'b0);
        check_ram("ram_wrap");

        // Reset at bit 50 of frame 3, then restart from address 0.
        do_reset(2);
        idle(3, 1'b1);
        burst(3 * 256 + 50);
        do_reset(1);
        idle(4, 1'b1);
        step(1'b1, 1'($urandom_range(0, 1)));
        chk("midrst_restart_addr", 32'(wr_addr), 32'h000);
        idle(2, 1'b0);
        check_ram("ram_midrst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
